// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver driven by a 16x oversampling tick.
// Synchronises rx_i, qualifies the start bit at mid-bit, samples the data
// bits LSB first at the end of each 16-tick bit window, checks the stop bit
// and offers the byte through a valid/ready holding register.
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing plus parity_err_o).
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_16x_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err_o,
`endif
    output logic       busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;

    logic                   rxs;
    logic                   stop_sample;
    logic                   commit;
    logic                   par_bad;

`ifdef UART_RX_PARITY_EN
    logic                   par_err_q, par_err_d;
    logic                   parity_err_q, parity_err_d;
    assign par_bad      = par_err_q;
    assign parity_err_o = parity_err_q;
`else
    assign par_bad      = 1'b0;
`endif

    // Oldest synchroniser stage is the only view of the line the FSM uses.
    assign rxs     = sync_q[SYNC_STAGES-1];
    assign sync_d  = {sync_q[SYNC_STAGES-2:0], rx_i};

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != S_IDLE);

    // Frame FSM: advances only on tick cycles, everything holds otherwise.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d   = par_err_q;
`endif
        if (tick_16x_i) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        state_d = S_START;
                        cnt_d   = 4'd0;
                    end
                end
                S_START: begin
                    if (cnt_q == 4'd7) begin
                        cnt_d = 4'd0;
                        if (!rxs) begin
                            state_d   = S_DATA;
                            bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                            par_err_d = 1'b0;
`endif
                        end else begin
                            // Line went back high before mid-bit: a glitch, not a start.
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == 4'd15) begin
                        cnt_d            = 4'd0;
                        shift_d[bit_idx_q] = rxs;
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                            state_d   = S_PARITY;
`else
                            state_d   = S_STOP;
`endif
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == 4'd15) begin
                        cnt_d     = 4'd0;
                        // Even parity: data bits and parity bit must XOR to zero.
                        par_err_d = par_err_q | (^{shift_q, rxs});
                        state_d   = S_STOP;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == 4'd15) begin
                        cnt_d       = 4'd0;
                        stop_sample = 1'b1;
                        // A low stop bit may be a break; wait for the line to recover.
                        state_d     = rxs ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rxs) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Holding register, handshake and error pulses.
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        commit      = stop_sample && rxs && !par_bad;
`ifdef UART_RX_PARITY_EN
        parity_err_d = stop_sample && par_err_q;
`endif
        if (stop_sample && (!rxs || par_bad)) begin
            frame_err_d = 1'b1;
        end
        if (commit) begin
            // A byte being accepted this cycle frees the register for the new one.
            if (!valid_q || ready_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            sync_q       <= '1;
            cnt_q        <= 4'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_err_q    <= par_err_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames with a frame-level reference model.
// Honours UART_RX_PARITY_EN for the 8E1 build.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       tick;
    logic       rx_i = 1'b1;
    logic       ready_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;
`ifdef UART_RX_PARITY_EN
    logic       parity_err_o;
    localparam int FRAME_TICKS = 168;
`else
    localparam int FRAME_TICKS = 152;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .tick_16x_i  (tick),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
`ifdef UART_RX_PARITY_EN
        .parity_err_o(parity_err_o),
`endif
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // 16x tick once every 4 clocks; tick_no is the index of the next tick edge.
    logic [1:0] tdiv = 2'd0;
    int         tick_no = 0;
    always @(posedge clk) tdiv <= tdiv + 2'd1;
    assign tick = (tdiv == 2'd3);
    always @(posedge clk) if (tick) tick_no <= tick_no + 1;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame outcome scheduled at the tick that samples the stop bit.
    typedef struct {
        int         idx;
        logic [7:0] b;
        bit         good;
        bit         perr;
    } ev_t;
    ev_t evq[$];

    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_fe    = 1'b0;
    logic       m_ov    = 1'b0;
    logic       m_pe    = 1'b0;

    // Reference model: holding register and pulses from frame outcomes.
    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            m_data  <= 8'h00;
            m_valid <= 1'b0;
            m_fe    <= 1'b0;
            m_ov    <= 1'b0;
            m_pe    <= 1'b0;
        end else begin
            m_fe <= 1'b0;
            m_ov <= 1'b0;
            m_pe <= 1'b0;
            if (tick && evq.size() > 0 && evq[0].idx == tick_no) begin
                if (evq[0].good) begin
                    if (!m_valid || ready_i) begin
                        m_data  <= evq[0].b;
                        m_valid <= 1'b1;
                    end else begin
                        m_ov <= 1'b1;
                    end
                end else begin
                    m_fe <= 1'b1;
                    m_pe <= evq[0].perr;
                    if (m_valid && ready_i) m_valid <= 1'b0;
                end
                void'(evq.pop_front());
            end else if (m_valid && ready_i) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, plus pulse counters.
    int fe_cnt = 0;
    int ov_cnt = 0;
    always @(negedge clk) begin
        chk1("valid_o", valid_o, m_valid);
        chk8("data_o", data_o, m_data);
        chk1("frame_err_o", frame_err_o, m_fe);
        chk1("overrun_o", overrun_o, m_ov);
`ifdef UART_RX_PARITY_EN
        chk1("parity_err_o", parity_err_o, m_pe);
`endif
        if (frame_err_o) fe_cnt++;
        if (overrun_o) ov_cnt++;
    end

    task automatic wait_tick();
        do @(posedge clk); while (!tick);
        #1;
    endtask

    task automatic drive_level(input logic v, input int nticks);
        rx_i = v;
        repeat (nticks) wait_tick();
    endtask

    task automatic pulse_ready(input int target);
        int guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (!(tick && tick_no == target) && guard < 2000);
        if (guard >= 2000) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_at_commit: commit tick %0d not reached, now %0d", target, tick_no);
        end
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit par_flip,
                              input int extra_low, input bit rdy_at_commit);
        ev_t e;
        wait_tick();
        e.idx  = tick_no + FRAME_TICKS;
        e.b    = b;
        e.good = stop_v && !par_flip;
        e.perr = par_flip;
        evq.push_back(e);
        fork
            begin
                drive_level(1'b0, 16);
                for (int i = 0; i < 8; i++) drive_level(b[i], 16);
`ifdef UART_RX_PARITY_EN
                drive_level((^b) ^ par_flip, 16);
`endif
                drive_level(stop_v, 16);
                if (extra_low > 0) drive_level(1'b0, extra_low);
            end
            begin
                if (rdy_at_commit) pulse_ready(e.idx);
            end
        join
    endtask

    task automatic consume();
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
    endtask

    initial begin
        int fe0;
        int ov0;
        rst_i   = 1'b0;
        rx_i    = 1'b1;
        ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("reset_valid", valid_o, 1'b0);
        chk8("reset_data", data_o, 8'h00);
        chk1("reset_frame_err", frame_err_o, 1'b0);
        chk1("reset_overrun", overrun_o, 1'b0);
        chk1("reset_busy", busy_o, 1'b0);
        rst_i = 1'b1;
        repeat (4) wait_tick();

        // Plain byte, held until a one-cycle ready.
        send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0);
        chk1("a5_valid", valid_o, 1'b1);
        chk8("a5_data", data_o, 8'hA5);
        chk1("a5_busy_idle", busy_o, 1'b0);
        consume();
        chk1("a5_consumed", valid_o, 1'b0);

        // Three-tick low glitch is rejected at the mid-start check.
        fe0 = fe_cnt;
        wait_tick();
        drive_level(1'b0, 3);
        chk1("glitch_busy", busy_o, 1'b1);
        drive_level(1'b1, 10);
        chk1("glitch_idle", busy_o, 1'b0);
        chk1("glitch_no_valid", valid_o, 1'b0);
        chk8("glitch_no_fe", 8'(fe_cnt - fe0), 8'd0);
        send_frame(8'h3C, 1'b1, 1'b0, 0, 1'b0);
        chk8("3c_data", data_o, 8'h3C);
        consume();

        // Low stop bit followed by a held-low line.
        fe0 = fe_cnt;
        send_frame(8'h81, 1'b0, 1'b0, 40, 1'b0);
        chk8("81_one_fe", 8'(fe_cnt - fe0), 8'd1);
        chk1("81_no_valid", valid_o, 1'b0);
        chk1("81_wait_high_busy", busy_o, 1'b1);
        drive_level(1'b1, 2);
        chk1("81_idle_after_rise", busy_o, 1'b0);
        send_frame(8'h7E, 1'b1, 1'b0, 0, 1'b0);
        chk1("7e_valid", valid_o, 1'b1);
        chk8("7e_data", data_o, 8'h7E);
        consume();

        // Second byte arrives while the first is unconsumed.
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, 1'b0, 0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 0, 1'b0);
        chk8("ovr_count", 8'(ov_cnt - ov0), 8'd1);
        chk8("ovr_keeps_old", data_o, 8'h11);
        chk1("ovr_valid", valid_o, 1'b1);
        consume();

        // Same pair, but the first byte is accepted in the commit cycle.
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, 1'b0, 0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 0, 1'b1);
        chk8("acc_commit_no_ovr", 8'(ov_cnt - ov0), 8'd0);
        chk8("acc_commit_data", data_o, 8'h22);
        chk1("acc_commit_valid", valid_o, 1'b1);
        consume();

        // Reset during data bit 4 with a byte still held.
        send_frame(8'h55, 1'b1, 1'b0, 0, 1'b0);
        chk8("55_held", data_o, 8'h55);
        wait_tick();
        drive_level(1'b0, 16);
        drive_level(1'b0, 64);
        drive_level(1'b1, 8);
        chk1("f0_busy_before_reset", busy_o, 1'b1);
        rst_i = 1'b0;
        evq.delete();
        #1;
        chk1("midrst_valid", valid_o, 1'b0);
        chk8("midrst_data", data_o, 8'h00);
        chk1("midrst_busy", busy_o, 1'b0);
        chk1("midrst_fe", frame_err_o, 1'b0);
        chk1("midrst_ovr", overrun_o, 1'b0);
        rx_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b1;
        send_frame(8'h0F, 1'b1, 1'b0, 0, 1'b0);
        chk1("0f_valid", valid_o, 1'b1);
        chk8("0f_data", data_o, 8'h0F);
        consume();

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the parity bit must be 1.
        send_frame(8'h07, 1'b1, 1'b0, 0, 1'b0);
        chk1("par_ok_valid", valid_o, 1'b1);
        chk8("par_ok_data", data_o, 8'h07);
        consume();
        fe0 = fe_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 0, 1'b0);
        chk8("par_bad_fe", 8'(fe_cnt - fe0), 8'd1);
        chk1("par_bad_no_valid", valid_o, 1'b0);
        chk1("par_bad_idle", busy_o, 1'b0);
`endif

        repeat (8) @(posedge clk);
        chk8("queue_drained", 8'(evq.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
